// File: rtl/word16_nib4_pkg.sv
// word16_nib4_pkg: shared widths, FSM state and nibble-counter type for the 16->4 serializer
package word16_nib4_pkg;
  localparam int WORD_W = 16;
  localparam int NIB_W = 4;
  localparam int NIBS_PER_WORD = 4;
  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [1:0] nib_cnt_t;
endpackage

// File: rtl/nib4_shift_reg.sv
// nib4_shift_reg: 16-bit load/shift register presenting one nibble at its output end
// Ports: clk, rst_n (sync, active-low), load/din (parallel load), shift (move one nibble
// toward the output end, zero fill), nib (current output nibble).
// MSB_FIRST=0 outputs q[3:0] and shifts right; MSB_FIRST=1 outputs q[15:12] and shifts left.
module nib4_shift_reg
  import word16_nib4_pkg::*;
#(
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic [NIB_W-1:0]  nib
);
  logic [WORD_W-1:0] q;
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= (MSB_FIRST != 0) ? {q[WORD_W-NIB_W-1:0], {NIB_W{1'b0}}}
                                          : {{NIB_W{1'b0}}, q[WORD_W-1:NIB_W]};
  assign nib = (MSB_FIRST != 0) ? q[WORD_W-1 -: NIB_W] : q[NIB_W-1:0];
endmodule

// File: rtl/word16_nib4_ser.sv
// word16_nib4_ser: serializes a 16-bit word into four 4-bit nibbles over valid/ready
// Ports: CLK, RESET_N (sync, active-low); input side I_DATA/I_VALID/I_READY;
// output side O_NIB/O_VALID/O_READY/O_LAST; BUSY while a word is held.
// Option macro SER_SHORT_ZERO_EXT_EN: words with I_DATA[15:4]==0 go out as a single nibble.
module word16_nib4_ser
  import word16_nib4_pkg::*;
#(
  parameter int MSB_FIRST = 0,
  parameter int BACK2BACK = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [WORD_W-1:0] I_DATA,
  input  logic              I_VALID,
  output logic              I_READY,
  output logic [NIB_W-1:0]  O_NIB,
  output logic              O_VALID,
  input  logic              O_READY,
  output logic              O_LAST,
  output logic              BUSY
);
  state_t state, state_n;
  nib_cnt_t nib_cnt, nib_cnt_n;
  logic short_q, short_n, short_in, fire, load, shift;
  logic [WORD_W-1:0] load_data;
`ifdef SER_SHORT_ZERO_EXT_EN
  assign short_in = I_DATA[WORD_W-1:NIB_W] == '0;
`else
  assign short_in = 1'b0;
`endif
  // a short word must present I_DATA[3:0] at whichever end the register drains from
  assign load_data = (short_in && MSB_FIRST != 0) ? {I_DATA[NIB_W-1:0], {(WORD_W-NIB_W){1'b0}}} : I_DATA;
  assign O_VALID = state == SEND;
  assign BUSY    = O_VALID;
  assign O_LAST  = O_VALID && (nib_cnt == nib_cnt_t'(NIBS_PER_WORD-1) || short_q);
  assign fire    = O_VALID && O_READY;
  // gated by RESET_N so the input side is closed while reset is asserted
  assign I_READY = RESET_N && (state == IDLE || (BACK2BACK != 0 && fire && O_LAST));
  assign load    = I_VALID && I_READY;
  assign shift   = fire && !O_LAST;
  always_ff @(posedge CLK)
    if (!RESET_N) begin
      state   <= IDLE;
      nib_cnt <= '0;
      short_q <= 1'b0;
    end else begin
      state   <= state_n;
      nib_cnt <= nib_cnt_n;
      short_q <= short_n;
    end
  always_comb begin
    state_n   = load ? SEND : (fire && O_LAST) ? IDLE : state;
    nib_cnt_n = load ? '0 : shift ? nib_cnt_t'(nib_cnt + 1'b1) : nib_cnt;
    short_n   = load ? short_in : short_q;
  end
  nib4_shift_reg #(.MSB_FIRST(MSB_FIRST)) u_sreg (
    .clk  (CLK),
    .rst_n(RESET_N),
    .load (load),
    .shift(shift),
    .din  (load_data),
    .nib  (O_NIB)
  );
endmodule

// File: tb/tb_word16_nib4_ser.sv
// tb_word16_nib4_ser: scoreboard bench driving an LSB-first and an MSB-first instance in lockstep
module tb_word16_nib4_ser;
  logic clk = 1'b0;
  logic rst_n, i_valid, o_ready;
  logic [15:0] i_data;
  logic i_ready_a, o_valid_a, o_last_a, busy_a;
  logic i_ready_b, o_valid_b, o_last_b, busy_b;
  logic [3:0] o_nib_a, o_nib_b;
  int total = 0;
  int bad = 0;
  int n;
  typedef struct packed {logic [3:0] a; logic [3:0] b; logic last;} exp_t;
  exp_t sb[$];
  logic stall = 1'b0;
  logic [3:0] hold_a, hold_b;
  logic hold_la, hold_lb;

  always #5 clk = ~clk;

  word16_nib4_ser #(.MSB_FIRST(0), .BACK2BACK(1)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .I_DATA(i_data), .I_VALID(i_valid), .I_READY(i_ready_a),
    .O_NIB(o_nib_a), .O_VALID(o_valid_a), .O_READY(o_ready), .O_LAST(o_last_a), .BUSY(busy_a));
  word16_nib4_ser #(.MSB_FIRST(1), .BACK2BACK(1)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .I_DATA(i_data), .I_VALID(i_valid), .I_READY(i_ready_b),
    .O_NIB(o_nib_b), .O_VALID(o_valid_b), .O_READY(o_ready), .O_LAST(o_last_b), .BUSY(busy_b));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_short(logic [15:0] w);
`ifdef SER_SHORT_ZERO_EXT_EN
    return w[15:4] == 12'h000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int beats(logic [15:0] w);
    return is_short(w) ? 1 : 4;
  endfunction

  task automatic push_word(logic [15:0] w);
    exp_t e;
    int nb = beats(w);
    for (int k = 0; k < nb; k++) begin
      e.a = 4'(w >> (4 * k));
      e.b = is_short(w) ? w[3:0] : 4'(w >> (4 * (3 - k)));
      e.last = (k == nb - 1);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk)
    if (rst_n && i_valid && i_ready_a) push_word(i_data);

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_nib", {o_nib_a, o_nib_b}, {hold_a, hold_b});
        check("stall_last", {o_last_a, o_last_b}, {hold_la, hold_lb});
        check("stall_valid", {o_valid_a, o_valid_b}, 2'b11);
      end
      if (o_valid_a && o_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got nibble %h expected no beat", o_nib_a);
        end else begin
          e = sb.pop_front();
          check("nib", {o_nib_a, o_nib_b}, {e.a, e.b});
          check("last", {o_last_a, o_last_b}, {2{e.last}});
          check("valid_b", o_valid_b, 1);
        end
      end
      stall = o_valid_a && !o_ready;
      hold_a = o_nib_a;
      hold_b = o_nib_b;
      hold_la = o_last_a;
      hold_lb = o_last_b;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] w, bit hold);
    bit ok = 1'b0;
    i_data = w;
    i_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = i_ready_a;
      step();
    end
    if (!hold) i_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_valid_a) break;
      cnt++;
      step();
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    o_ready = 1'b1;
    step();
    @(negedge clk);
    check("rst_i_ready", {i_ready_a, i_ready_b}, 2'b00);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_i_ready", {i_ready_a, i_ready_b}, 2'b11);
    check("post_rst_valid", {o_valid_a, o_valid_b}, 2'b00);
    check("post_rst_last", {o_last_a, o_last_b}, 2'b00);
    check("post_rst_nib", {o_nib_a, o_nib_b}, 8'h00);
    check("post_rst_busy", {busy_a, busy_b}, 2'b00);
    step();
    // single word with latency-1 first nibble
    send(16'hA5C3, 1'b0);
    @(negedge clk);
    check("lat1_valid", {o_valid_a, o_valid_b}, 2'b11);
    check("lat1_nib", {o_nib_a, o_nib_b}, 8'h3A);
    wait_idle(n);
    check("single_beats", n, 3);
    @(negedge clk);
    check("single_busy_fall", {busy_a, busy_b}, 2'b00);
    check("single_i_ready", {i_ready_a, i_ready_b}, 2'b11);
    step();
    // backpressure on the second nibble
    send(16'hA5C3, 1'b0);
    step();
    o_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_nib", {o_nib_a, o_nib_b}, 8'hC5);
      check("bp_valid", {o_valid_a, o_valid_b}, 2'b11);
      step();
    end
    o_ready = 1'b1;
    wait_idle(n);
    check("bp_beats", n, 3);
    // back-to-back with I_VALID held
    send(16'h1234, 1'b1);
    i_data = 16'hBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("b2b_valid", o_valid_a, 1);
      check("b2b_i_ready", i_ready_a, c == 3);
      step();
    end
    i_valid = 1'b0;
    wait_idle(n);
    check("b2b_second_beats", n, 4);
    // reset in the middle of a word
    send(16'hFFFF, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", {o_valid_a, o_valid_b}, 2'b00);
    check("midrst_busy", {busy_a, busy_b}, 2'b00);
    check("midrst_i_ready", {i_ready_a, i_ready_b}, 2'b11);
    step();
    send(16'h0001, 1'b0);
    wait_idle(n);
    check("w0001_beats", n, beats(16'h0001));
    // short-word candidates
    send(16'h0007, 1'b0);
    wait_idle(n);
    check("w0007_beats", n, beats(16'h0007));
    @(negedge clk);
    check("w0007_i_ready", {i_ready_a, i_ready_b}, 2'b11);
    step();
    send(16'h0017, 1'b0);
    wait_idle(n);
    check("w0017_beats", n, 4);
    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      o_ready = $urandom_range(0, 3) != 0;
      step();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (10) step();
    check("sb_drained", sb.size(), 0);
    check("end_idle", {busy_a, busy_b}, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
